// File: rtl/dram_burst_ctrl_pkg.sv
// Shared types and defaults for the L1-to-DRAM burst controller.
// Line geometry defaults match the L1 datapath.
package dram_burst_ctrl_pkg;

  localparam int unsigned LINE_WORDS_DEF = 8;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned ADDR_W_DEF     = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BURST = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_DRAIN = 3'd3,
    ST_ACK      = 3'd4,
    ST_RELEASE  = 3'd5
  } state_t;

  // States in which read returns are accepted into the line buffer.
  function automatic logic is_read_state(input state_t s);
    return (s == ST_RD_ISSUE) || (s == ST_RD_DRAIN);
  endfunction

endpackage

// File: rtl/dram_line_buffer.sv
// Holds the latched victim line and assembles the refill line word by word.
// The refill line is published to the L1 only on commit, so it stays stable between reads.
module dram_line_buffer #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [LINE_WORDS*DATA_W-1:0]     wline_in,
  input  logic                             cap,
  input  logic [$clog2(LINE_WORDS)-1:0]    cap_idx,
  input  logic [DATA_W-1:0]                cap_data,
  input  logic                             commit,
  input  logic [$clog2(LINE_WORDS)-1:0]    sel_idx,
  output logic [DATA_W-1:0]                sel_word_c,
  output logic [LINE_WORDS*DATA_W-1:0]     rline
);

  typedef logic [LINE_WORDS-1:0][DATA_W-1:0] line_t;

  line_t wline_q, wline_d;
  line_t asm_q, asm_d;
  line_t rline_q;

  // Next-state view lets the beat mux serve the word being latched this cycle.
  always_comb begin
    wline_d = wline_q;
    asm_d   = asm_q;
    if (load) wline_d = wline_in;
    if (cap)  asm_d[cap_idx] = cap_data;
  end

  assign sel_word_c = wline_d[sel_idx];
  assign rline      = rline_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wline_q <= '0;
      asm_q   <= '0;
      rline_q <= '0;
    end else begin
      wline_q <= wline_d;
      asm_q   <= asm_d;
      if (commit) rline_q <= asm_d;
    end
  end

endmodule

// File: rtl/dram_burst_ctrl.sv
// Turns one L1 line request into LINE_WORDS single-word beats on the external
// memory bus, assembling refill data and acking the L1 once the line is done.
module dram_burst_ctrl
  import dram_burst_ctrl_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dram_cs,
  input  logic                         dram_we,
  input  logic [ADDR_W-1:0]            dram_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] dram_wdata,
  output logic [LINE_WORDS*DATA_W-1:0] dram_rdata,
  output logic                         dram_ack,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_gnt,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rvalid
);

  localparam int unsigned LWB       = $clog2(LINE_WORDS);
  localparam int unsigned CW        = LWB + 1;
  localparam int unsigned BYTE_BITS = $clog2(DATA_W / 8);
  localparam int unsigned OFF_BITS  = LWB + BYTE_BITS;

  state_t            state, next_state;
  logic [CW-1:0]     issue_cnt, issue_cnt_d;
  logic [CW-1:0]     ret_cnt, ret_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic grant, last_grant, cap, last_ret, ret_full, load, commit;
  logic              mem_req_d, mem_we_d, dram_ack_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, sel_word_c;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^dram_addr[OFF_BITS-1:0];

  assign grant      = mem_req & mem_gnt;
  assign last_grant = grant && (issue_cnt == CW'(LINE_WORDS - 1));
  assign ret_full   = (ret_cnt == CW'(LINE_WORDS));
  assign cap        = mem_rvalid && is_read_state(state) && !ret_full;
  assign last_ret   = cap && (ret_cnt == CW'(LINE_WORDS - 1));
  assign load       = (state == ST_IDLE) && dram_cs;
  assign commit     = is_read_state(state) && (next_state == ST_ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (dram_cs) next_state = dram_we ? ST_WR_BURST : ST_RD_ISSUE;
      ST_WR_BURST: if (last_grant) next_state = ST_ACK;
      ST_RD_ISSUE: if (last_grant) next_state = (last_ret || ret_full) ? ST_ACK : ST_RD_DRAIN;
      ST_RD_DRAIN: if (last_ret || ret_full) next_state = ST_ACK;
      ST_ACK:      next_state = ST_RELEASE;
      ST_RELEASE:  if (!dram_cs) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Next values for counters, base and the registered bus outputs.
  always_comb begin
    issue_cnt_d = issue_cnt;
    ret_cnt_d   = ret_cnt;
    base_d      = base_q;
    if (state == ST_IDLE) begin
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
    end
    if (state == ST_WR_BURST || state == ST_RD_ISSUE) issue_cnt_d = issue_cnt + CW'(grant);
    if (is_read_state(state)) ret_cnt_d = ret_cnt + CW'(cap);
    if (load) base_d = {dram_addr[ADDR_W-1:OFF_BITS], OFF_BITS'(0)};

    mem_req_d   = (next_state == ST_WR_BURST) || (next_state == ST_RD_ISSUE);
    mem_we_d    = (next_state == ST_WR_BURST);
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    dram_ack_d  = (state == ST_ACK);
    // Beat offset wraps inside the line; the base keeps its aligned upper bits.
    if (mem_req_d)
      mem_addr_d = {base_d[ADDR_W-1:OFF_BITS], issue_cnt_d[LWB-1:0], BYTE_BITS'(0)};
    if (mem_we_d) mem_wdata_d = sel_word_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
      base_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dram_ack  <= 1'b0;
    end else begin
      issue_cnt <= issue_cnt_d;
      ret_cnt   <= ret_cnt_d;
      base_q    <= base_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      dram_ack  <= dram_ack_d;
    end
  end

  dram_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .DATA_W     (DATA_W)
  ) u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .wline_in   (dram_wdata),
    .cap        (cap),
    .cap_idx    (ret_cnt[LWB-1:0]),
    .cap_data   (mem_rdata),
    .commit     (commit),
    .sel_idx    (issue_cnt_d[LWB-1:0]),
    .sel_word_c (sel_word_c),
    .rline      (dram_rdata)
  );

endmodule
